// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar tile.
// Optional build macro used by the tile: CIM_XBAR_PROTO_CHECK_EN.
package cim_pkg;

  typedef enum logic {IDLE, COMPUTE} cim_tile_state_e;

  // Accumulator width that can hold a full column sum without overflow.
  function automatic int cim_acc_w(int xbar_size, int datatype_size);
    return datatype_size + $clog2(xbar_size);
  endfunction

endpackage

// File: rtl/cim_xbar_tile_if.sv
// Layer <-> crossbar tile bus. The layer is the master, the tile is the slave.
// CIM_XBAR_PROTO_CHECK_EN adds the sticky o_proto_err status line.
interface cim_xbar_tile_if #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8
);
  localparam int AW = $clog2(xbar_size);

  logic                     i_cim_we;
  logic [AW-1:0]            i_cim_wr_addr;
  logic [datatype_size-1:0] i_cim_data;
  logic                     i_w_we;
  logic [AW-1:0]            i_w_row;
  logic [xbar_size-1:0]     i_w_data;
  logic                     i_compute_start;
  logic                     o_cim_busy;
  logic [AW-1:0]            i_cim_rd_addr;
  logic [datatype_size-1:0] o_data;
`ifdef CIM_XBAR_PROTO_CHECK_EN
  logic                     o_proto_err;

  modport master (
    output i_cim_we, i_cim_wr_addr, i_cim_data, i_w_we, i_w_row, i_w_data,
           i_compute_start, i_cim_rd_addr,
    input  o_cim_busy, o_data, o_proto_err
  );
  modport slave (
    input  i_cim_we, i_cim_wr_addr, i_cim_data, i_w_we, i_w_row, i_w_data,
           i_compute_start, i_cim_rd_addr,
    output o_cim_busy, o_data, o_proto_err
  );
`else
  modport master (
    output i_cim_we, i_cim_wr_addr, i_cim_data, i_w_we, i_w_row, i_w_data,
           i_compute_start, i_cim_rd_addr,
    input  o_cim_busy, o_data
  );
  modport slave (
    input  i_cim_we, i_cim_wr_addr, i_cim_data, i_w_we, i_w_row, i_w_data,
           i_compute_start, i_cim_rd_addr,
    output o_cim_busy, o_data
  );
`endif
endinterface

// File: rtl/cim_col_adc.sv
// Column "ADC": right-shift one accumulator and clamp it to the output width.
module cim_col_adc #(
  parameter int acc_w         = 16,
  parameter int datatype_size = 8,
  parameter int adc_shift     = 0
) (
  input  logic [acc_w-1:0]         acc,
  output logic [datatype_size-1:0] res
);
  localparam logic [acc_w-1:0] MAX = acc_w'((1 << datatype_size) - 1);

  logic [acc_w-1:0] shifted;

  assign shifted = acc >> adc_shift;
  assign res     = (shifted > MAX) ? MAX[datatype_size-1:0] : shifted[datatype_size-1:0];
endmodule

// File: rtl/cim_xbar_tile.sv
// Behavioural CIM crossbar tile: input buffer + 1-bit weight array, one row
// accumulated per cycle into every column, results banked separately so reads
// during a compute return the previous MVM.
// Optional: CIM_XBAR_PROTO_CHECK_EN adds a sticky error flag for bus activity
// while busy.
module cim_xbar_tile
  import cim_pkg::*;
#(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8,
  parameter int adc_shift     = $clog2(xbar_size)
) (
  input logic            clk,
  input logic            rst,
  cim_xbar_tile_if.slave bus
);
  localparam int AW    = $clog2(xbar_size);
  localparam int ACC_W = cim_acc_w(xbar_size, datatype_size);

  cim_tile_state_e state, state_nxt;
  logic [AW-1:0]   row;
  logic            idle, last_row;

  logic [datatype_size-1:0]                 in_buf [xbar_size];
  logic [xbar_size-1:0]                     w_mem  [xbar_size];
  logic [xbar_size-1:0][ACC_W-1:0]          acc, acc_nxt;
  logic [xbar_size-1:0][datatype_size-1:0]  result, adc_out;

  assign idle           = (state == IDLE);
  assign last_row       = (row == AW'(xbar_size - 1));
  assign bus.o_cim_busy = (state == COMPUTE);

  // State register; reset aborts any compute in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only honoured when idle, leave after the last row.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_compute_start) state_nxt = COMPUTE;
      COMPUTE: if (last_row)            state_nxt = IDLE;
    endcase
  end

  // Storage writes only while idle; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (idle && bus.i_cim_we) in_buf[bus.i_cim_wr_addr] <= bus.i_cim_data;
    if (idle && bus.i_w_we)   w_mem[bus.i_w_row]        <= bus.i_w_data;
  end

  // Per-column accumulate of the current row and its shift/saturate. The ADC
  // sees the sum including the current row so the last row lands in result.
  for (genvar c = 0; c < xbar_size; c++) begin : g_col
    assign acc_nxt[c] = acc[c] + (w_mem[row][c] ? ACC_W'(in_buf[row]) : '0);

    cim_col_adc #(
      .acc_w        (ACC_W),
      .datatype_size(datatype_size),
      .adc_shift    (adc_shift)
    ) u_adc (
      .acc(acc_nxt[c]),
      .res(adc_out[c])
    );
  end

  // Row sweep: clear on start, accumulate one row per cycle, bank on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      row    <= '0;
      result <= '0;
    end else if (idle) begin
      if (bus.i_compute_start) begin
        acc <= '0;
        row <= '0;
      end
    end else begin
      acc <= acc_nxt;
      row <= row + AW'(1);
      if (last_row) result <= adc_out;
    end
  end

  // Registered column read, one cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.o_data <= '0;
    else     bus.o_data <= result[bus.i_cim_rd_addr];
  end

`ifdef CIM_XBAR_PROTO_CHECK_EN
  // Sticky flag: any write or start seen while computing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.o_proto_err <= 1'b0;
    else if (!idle && (bus.i_cim_we || bus.i_w_we || bus.i_compute_start))
      bus.o_proto_err <= 1'b1;
  end
`endif

endmodule
